// File: rtl/usart_rx_sipo.sv
// ============================================================================
// usart_rx_sipo
//   Serial-in / parallel-out USART receiver (8N1, LSB first, idle-high line).
//   Each bit is sampled near its midpoint by a clock-count bit timer. The
//   received byte is held on DATA_OUT until the consumer acknowledges it.
//   Framing errors pulse for one cycle; lost bytes raise a sticky overrun flag.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (even, >= 4)
//   CNT_W        : bit-timer width, 2**CNT_W > CLKS_PER_BIT
//
// Ports
//   CLK         in   system clock, rising edge
//   CLR         in   asynchronous active-low reset
//   SERIAL_IN   in   asynchronous serial line, idle high
//   RD_ACK      in   consumer strobe, clears RX_FULL
//   DATA_OUT    out  [7:0] last received byte
//   RX_FULL     out  DATA_OUT holds an unread byte
//   FRAMING_ERR out  one-cycle pulse when the stop bit is sampled low
//   OVERRUN     out  sticky: a byte was dropped because RX_FULL was set
//   BUSY        out  high whenever the receiver is not idle
// ============================================================================
module usart_rx_sipo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       SERIAL_IN,
    input  logic       RD_ACK,
    output logic [7:0] DATA_OUT,
    output logic       RX_FULL,
    output logic       FRAMING_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Timer terminal counts: the start bit is checked after half a bit so that
    // every later sample lands one full bit period further, i.e. mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_full;
    logic             r_ferr;
    logic             r_ovr;
    logic             r_busy;

    logic             w_rx_s;
    logic             w_half_done;
    logic             w_bit_done;

    assign w_rx_s      = r_sync2;
    assign w_half_done = (r_timer == HALF_LAST);
    assign w_bit_done  = (r_timer == BIT_LAST);

    assign DATA_OUT    = r_data;
    assign RX_FULL     = r_full;
    assign FRAMING_ERR = r_ferr;
    assign OVERRUN     = r_ovr;
    assign BUSY        = r_busy;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= SERIAL_IN;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_full    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;

            // An acknowledge empties the holding register; a stop-bit load on
            // the same edge (below) overrides this and keeps RX_FULL set.
            if (RD_ACK) begin
                r_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_half_done) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            // Line went back high: a glitch, not a frame.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        r_timer   <= '0;
                        // LSB arrives first; after eight right shifts it sits in bit 0.
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            // A same-edge acknowledge frees the register, so
                            // the new byte is loaded rather than dropped.
                            if (!r_full || RD_ACK) begin
                                r_data <= r_shift;
                                r_full <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                S_BREAK: begin
                    // Hold off until the line returns high so a stuck-low
                    // line cannot be decoded as a stream of zero frames.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/usart_rx_sipo.md
Name: usart_rx_sipo

Overview:
Serial-in/parallel-out USART receiver. It is the receive-side counterpart of the team's PISO transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle line high.
- Samples each bit at its midpoint using a clock-count bit timer, then presents the byte on a parallel bus.
- The byte is held until the consumer acknowledges it. Framing errors and overruns are flagged.

Parameters:
- CLKS_PER_BIT, 16: CLK cycles per serial bit. Must be even and ≥ 4.
- CNT_W, 8: width of the bit-timer counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  input  1  system clock; everything is sampled on the rising edge.
- CLR  input  1  asynchronous, active-low reset (0 = reset).
- SERIAL_IN  input  1  asynchronous serial line, idle high.
- RD_ACK  input  1  consumer strobe; clears RX_FULL.
- DATA_OUT  output  8  last received byte.
- RX_FULL  output  1  DATA_OUT holds an unread byte.
- FRAMING_ERR  output  1  one-cycle pulse when the stop bit is sampled as 0.
- OVERRUN  output  1  sticky flag: a byte was lost because RX_FULL was still set.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (CLR=0, takes effect immediately, independent of CLK):
  - DATA_OUT=8'h00, RX_FULL=0, FRAMING_ERR=0, OVERRUN=0, BUSY=0.
  - FSM goes to IDLE; bit counter, timer and shift register clear.
  - Both synchronizer flops reset to 1.
- Input synchronization:
  - SERIAL_IN passes through a 2-flop synchronizer, producing rx_s.
  - All decisions use rx_s only, so there are 2 cycles of input latency.
- IDLE:
  - rx_s==0 → START, timer cleared.
- START:
  - Wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s==0 → DATA, timer cleared, bit index 0.
  - rx_s==1 → glitch/false start → IDLE with no flags raised.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift[bit index].
  - Shift is right-shift with the new bit entering at the MSB, so the first bit received ends up as DATA_OUT[0].
  - After the 8th sample → STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If rx_s==1 and RX_FULL==0: DATA_OUT←shift and RX_FULL←1 on the same edge.
  - If rx_s==1 and RX_FULL==1: DATA_OUT is unchanged, the new byte is discarded, OVERRUN←1.
  - Either case → IDLE.
  - If rx_s==0: FRAMING_ERR pulses for exactly 1 cycle, the byte is discarded, DATA_OUT and RX_FULL are unchanged → BREAK.
- BREAK:
  - Remain here until rx_s==1, then → IDLE.
  - This prevents a stuck-low line from producing repeated frames.
- Handshake:
  - RD_ACK=1 clears RX_FULL on the next edge. RD_ACK while RX_FULL=0 has no effect.
  - RD_ACK does not clear OVERRUN; only CLR does.
- Simultaneous RD_ACK and stop-bit load:
  - The load wins: RX_FULL stays 1 with the new DATA_OUT. No overrun, because the old byte is treated as consumed.
- Latency: from the SERIAL_IN start edge to RX_FULL rising is 2 (sync) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles, ±1 cycle of edge-phase uncertainty.
- Back-to-back frames: a new start bit immediately after a valid stop sample is accepted, i.e. the FSM is in IDLE on the next cycle.
- Reset asserted mid-frame: the partial byte is lost and all outputs take their reset values at once.

Test Plan:
1. Single frame. Setup: CLKS_PER_BIT=4, send 8'h0B.
   - Required: RX_FULL=1 and DATA_OUT=8'h0B after 2+2+36 cycles ±1.
   - Required: BUSY is high throughout the frame; FRAMING_ERR and OVERRUN stay 0.
2. Glitch rejection. Stimulus: a 1-cycle low pulse on SERIAL_IN.
   - Required: returns to IDLE; RX_FULL, FRAMING_ERR and DATA_OUT are unchanged.
3. Framing error. Stimulus: send 8'hA5 with the stop bit driven 0, then hold the line low for 20 cycles, then release it high.
   - Required: exactly one FRAMING_ERR pulse; RX_FULL stays 0; BUSY stays high until the line goes high; no second frame is detected.
4. Overrun. Stimulus: send 8'h55 then 8'hAA back-to-back with no RD_ACK.
   - Required: DATA_OUT=8'h55 and OVERRUN=1.
   - Then pulse RD_ACK → RX_FULL=0 and OVERRUN remains 1.
5. Same-edge RD_ACK. Stimulus: with 8'h55 held, assert RD_ACK on the cycle the stop bit of 8'h3C is sampled.
   - Required: DATA_OUT=8'h3C, RX_FULL=1, OVERRUN=0.
6. Reset mid-frame. Stimulus: drop CLR during data bit 4 of 8'hFF.
   - Required: all outputs 0 at once (DATA_OUT=8'h00), BUSY=0.
   - Required: after release, a clean 8'h81 frame is received correctly.
